// File: rtl/red_pitaya_pwm_pkg.sv
// Shared types and constants for the PWM receiver: FSM encoding, frame geometry
// and output word widths.
package red_pitaya_pwm_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } pwm_state_t;

  localparam int NSUB    = 16;
  localparam int DUTY_W  = 9;
  localparam int VALUE_W = 13;

  // Cycles between on-time sync pulses for a given period end value.
  function automatic int frame_len(input int full);
    return NSUB * (full + 1);
  endfunction

endpackage

// File: rtl/red_pitaya_sync_ff.sv
// N-stage flop synchronizer for a single-bit input; STAGES=0 is a straight wire
// for on-chip loopback sources.
module red_pitaya_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic sync_unused;
      assign sync_unused = clk ^ rstn;
      assign q = d;
    end else begin : g_sync
      logic [STAGES-1:0] sync_pipe;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_pipe <= '0;
        else       sync_pipe <= (sync_pipe << 1) | STAGES'(d);
      end
      assign q = sync_pipe[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/red_pitaya_pwm_rx.sv
// PWM demodulator: counts high samples per period and per 16-period frame,
// aligned to the transmitter sync pulse, with sync supervision.
module red_pitaya_pwm_rx
  import red_pitaya_pwm_pkg::*;
#(
  parameter logic [7:0] FULL        = 8'd255,
  parameter int         SYNC_STAGES = 2,
  parameter int         SYNC_DLY    = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pwm_i,
  input  logic               sync_i,
  input  logic               err_clr_i,
  output logic [DUTY_W-1:0]  duty_o,
  output logic               duty_valid_o,
  output logic [VALUE_W-1:0] value_o,
  output logic               value_valid_o,
  output logic               locked_o,
  output logic               err_o
);

  localparam int            FRAME = frame_len(int'(FULL));
  localparam int            TW    = $clog2(FRAME);
  localparam logic [TW-1:0] TMAX  = TW'(FRAME - 1);
  localparam logic [7:0]    DLY   = 8'(SYNC_DLY);

  pwm_state_t         state;
  logic [7:0]         dcnt, pcnt;
  logic [3:0]         scnt;
  logic [DUTY_W-1:0]  hcnt, hsum;
  logic [VALUE_W-1:0] acc, vsum;
  logic [TW-1:0]      tcnt;
  logic               s, early, miss, start, align_done, enter, count, err_set;

  red_pitaya_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (pwm_i),
    .q    (s)
  );

  // Any sync outside LOCKED (or an off-time one inside it) restarts alignment
  // from that pulse; an on-time sync in LOCKED only rearms the timer.
  assign early      = (state == LOCKED) && sync_i && (tcnt != TMAX);
  assign miss       = (state == LOCKED) && !sync_i && (tcnt == TMAX);
  assign start      = sync_i && ((state != LOCKED) || early);
  assign align_done = (state == ALIGN) && !start && (dcnt == 8'd1);
  assign enter      = (start && SYNC_DLY == 0) || align_done;
  assign count      = (state == LOCKED) && !early;
  assign err_set    = early || miss;
  assign hsum       = hcnt + DUTY_W'(s);
  assign vsum       = acc + VALUE_W'(hsum);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= SEARCH;
      dcnt     <= '0;
      tcnt     <= '0;
      locked_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (start) begin
        state <= (SYNC_DLY == 0) ? LOCKED : ALIGN;
        dcnt  <= DLY;
      end else if (miss) begin
        state <= SEARCH;
      end else if (align_done) begin
        state <= LOCKED;
      end else if (state == ALIGN) begin
        dcnt <= dcnt - 8'd1;
      end
      tcnt     <= sync_i ? '0 : (tcnt == TMAX) ? tcnt : tcnt + TW'(1);
      locked_o <= (enter && !early) || (count && !miss);
      err_o    <= err_set || (err_o && !err_clr_i);
    end
  end

  // An early sync leaves count low, so the broken frame never strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt          <= '0;
      scnt          <= '0;
      hcnt          <= '0;
      acc           <= '0;
      duty_o        <= '0;
      duty_valid_o  <= 1'b0;
      value_o       <= '0;
      value_valid_o <= 1'b0;
    end else begin
      duty_valid_o  <= 1'b0;
      value_valid_o <= 1'b0;
      if (enter) begin
        pcnt <= '0;
        scnt <= '0;
        hcnt <= '0;
        acc  <= '0;
      end else if (count) begin
        if (pcnt == FULL) begin
          pcnt         <= '0;
          scnt         <= scnt + 4'd1;
          hcnt         <= '0;
          duty_o       <= hsum;
          duty_valid_o <= 1'b1;
          if (scnt == 4'(NSUB - 1)) begin
            value_o       <= vsum;
            value_valid_o <= 1'b1;
            acc           <= '0;
          end else begin
            acc <= vsum;
          end
        end else begin
          pcnt <= pcnt + 8'd1;
          hcnt <= hsum;
        end
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pwm_rx.sv
// Directed bench for red_pitaya_pwm_rx: a loopback instance (0 stages, no delay)
// and a synchronized instance (2 stages, delay 2) on a shared clock.
module tb_red_pitaya_pwm_rx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pwm0 = 1'b0, sync0 = 1'b0, clr0 = 1'b0;
  logic        pwm1 = 1'b0, sync1 = 1'b0, clr1 = 1'b0;
  logic [8:0]  duty0, duty1;
  logic [12:0] value0, value1;
  logic        dv0, vv0, lk0, er0, dv1, vv1, lk1, er1;
  int          checks = 0;
  int          errors = 0;
  int          dstb0 = 0, vstb0 = 0, d_ref = 0, v_ref = 0;

  always #5 clk = ~clk;

  red_pitaya_pwm_rx #(.FULL(8'd255), .SYNC_STAGES(0), .SYNC_DLY(0)) dut0 (
    .clk(clk), .rstn(rstn), .pwm_i(pwm0), .sync_i(sync0), .err_clr_i(clr0),
    .duty_o(duty0), .duty_valid_o(dv0), .value_o(value0), .value_valid_o(vv0),
    .locked_o(lk0), .err_o(er0)
  );

  red_pitaya_pwm_rx #(.FULL(8'd255), .SYNC_STAGES(2), .SYNC_DLY(2)) dut1 (
    .clk(clk), .rstn(rstn), .pwm_i(pwm1), .sync_i(sync1), .err_clr_i(clr1),
    .duty_o(duty1), .duty_valid_o(dv1), .value_o(value1), .value_valid_o(vv1),
    .locked_o(lk1), .err_o(er1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (dv0) dstb0++;
    if (vv0) vstb0++;
  endtask

  // Drive nk cycles of one transmitter frame into dut0 (sample k of the frame),
  // checking each period's duty and optionally the frame value.
  task automatic run(input int hi, input logic [15:0] dith, input int sync_k,
                     input int nk, input int exp_val, input int clr_k);
    for (int k = 0; k < nk; k++) begin
      int p;
      int sb;
      int expd;
      p    = k % 256;
      sb   = k / 256;
      expd = hi + (dith[sb] ? 1 : 0);
      pwm0  = (p < expd);
      sync0 = (k == sync_k);
      clr0  = (k == clr_k);
      tick();
      if (p == 255) begin
        check($sformatf("dvld k=%0d", k), dv0, 1);
        check($sformatf("duty k=%0d", k), duty0, expd);
      end
      if (k == 4095 && exp_val >= 0) begin
        check("vvld", vv0, 1);
        check("value", value0, exp_val);
      end
    end
    pwm0  = 1'b0;
    sync0 = 1'b0;
    clr0  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst duty", duty0, 0);
    check("rst dvld", dv0, 0);
    check("rst value", value0, 0);
    check("rst vvld", vv0, 0);
    check("rst locked", lk0, 0);
    check("rst err", er0, 0);
    check("rst locked1", lk1, 0);
    rstn = 1'b1;
    tick();

    // constant high, two frames
    d_ref = dstb0;
    v_ref = vstb0;
    sync0 = 1'b1; tick(); sync0 = 1'b0;
    run(256, 16'h0000, 4095, 4096, 4096, -1);
    run(256, 16'h0000, 4095, 4096, 4096, -1);
    check("t1 dstb", dstb0 - d_ref, 32);
    check("t1 vstb", vstb0 - v_ref, 2);
    check("t1 locked", lk0, 1);
    check("t1 err", er0, 0);

    // dithered 0x12 + bits of 0x3456
    run(18, 16'h3456, 4095, 4096, 295, -1);

    // early sync kills the frame; the next frame is clean
    v_ref = vstb0;
    run(32, 16'h0000, 4094, 4095, -1, -1);
    check("t3 err", er0, 1);
    check("t3 locked", lk0, 0);
    check("t3 no vstb", vstb0 - v_ref, 0);
    run(32, 16'h0000, 4095, 4096, 512, 100);
    check("t3 err clr", er0, 0);
    check("t3 relock", lk0, 1);

    // missing sync; clear in the same cycle loses to the new error
    run(32, 16'h0000, -1, 4096, -1, 4095);
    check("t4 err set wins", er0, 1);
    check("t4 locked", lk0, 0);
    repeat (5) tick();
    check("t4 search locked", lk0, 0);
    check("t4 sticky", er0, 1);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    check("t4 err clr", er0, 0);
    sync0 = 1'b1; tick(); sync0 = 1'b0;
    run(64, 16'h0000, 4095, 4096, 1024, -1);
    check("t4 relock", lk0, 1);
    check("t4 err", er0, 0);

    // asynchronous reset mid-period at pcnt=100
    run(256, 16'h0000, -1, 101, -1, -1);
    check("t5 pre locked", lk0, 1);
    check("t5 pre duty", duty0, 64);
    check("t5 pre value", value0, 1024);
    #2 rstn = 1'b0;
    #1;
    check("t5 duty", duty0, 0);
    check("t5 dvld", dv0, 0);
    check("t5 value", value0, 0);
    check("t5 vvld", vv0, 0);
    check("t5 locked", lk0, 0);
    check("t5 err", er0, 0);
    tick();
    rstn = 1'b1;
    pwm0 = 1'b1;
    d_ref = dstb0;
    repeat (300) tick();
    check("t5 no stb presync", dstb0 - d_ref, 0);
    check("t5 search", lk0, 0);
    sync0 = 1'b1; tick(); sync0 = 1'b0;
    repeat (255) tick();
    check("t5 no stb early", dstb0 - d_ref, 0);
    tick();
    check("t5 first dvld", dv0, 1);
    check("t5 first duty", duty0, 256);
    check("t5 stb count", dstb0 - d_ref, 1);
    pwm0 = 1'b0;

    // synchronized instance: single high sample at the last slot of period 0
    sync1 = 1'b1; tick(); sync1 = 1'b0;
    for (int k = 0; k < 4098; k++) begin
      int j;
      pwm1  = (k == 255);
      sync1 = (k == 4095);
      tick();
      j = k - 2;
      if (j >= 0 && j % 256 == 255) begin
        check($sformatf("t6 dvld j=%0d", j), dv1, 1);
        check($sformatf("t6 duty j=%0d", j), duty1, (j == 255) ? 1 : 0);
      end
      if (j == 4095) begin
        check("t6 vvld", vv1, 1);
        check("t6 value", value1, 1);
      end
    end
    pwm1  = 1'b0;
    sync1 = 1'b0;
    check("t6 locked", lk1, 1);
    check("t6 err", er1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/red_pitaya_pwm_rx.md
# red_pitaya_pwm_rx

PWM receiver/demodulator: recovers the dithered duty-cycle value carried by the board's 8-bit-period, 16-subperiod PWM waveform. It samples a PWM line (loopback or external pin) framed by the transmitter's one-cycle sync pulse. It reports the per-period high count and the 16-period accumulated value, an 8.4 fixed-point word. It sits beside the PWM transmitters in the analog-mixed-signal housekeeping path, for self-test and readback of slow-DAC outputs.

## Interface
- FULL, 8'd255: last counter value of one PWM period; a period is FULL+1 cycles.
- SYNC_STAGES, 2: synchronizer flops on pwm_i, range 0..3. Use 0 for on-chip loopback.
- SYNC_DLY, 1: cycles from the sampled sync_i pulse to the first sample of a new frame, range 0..FULL.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- pwm_i  in  1  PWM waveform to measure
- sync_i  in  1  frame sync pulse, one cycle, once per 16 periods; clk domain
- err_clr_i  in  1  clears err_o
- duty_o  out  9  high-sample count of the last complete period, 0..FULL+1
- duty_valid_o  out  1  one-cycle strobe; duty_o updated
- value_o  out  13  sum of 16 duty counts, 8.4 format, 0..16*(FULL+1)
- value_valid_o  out  1  one-cycle strobe; value_o updated
- locked_o  out  1  frame alignment established and sync seen on time
- err_o  out  1  sticky: sync early or late, or missing

## Operation
- pwm_i passes through SYNC_STAGES flops, giving the sample s. Samples are counted only in LOCKED.
- Counters:
  - pcnt 8b, period position 0..FULL.
  - scnt 4b, subperiod 0..15.
  - hcnt 9b, high samples in the current period.
  - acc 13b, sum of duties in the current frame.
  - tcnt, sync timer 0..16*(FULL+1)-1.
- FSM states:
  - SEARCH: reset state. Waits for sync_i; on sync_i it loads dcnt=SYNC_DLY and goes to ALIGN.
  - ALIGN: counts dcnt down. At 0 it clears pcnt, scnt, hcnt and acc, then goes to LOCKED. With SYNC_DLY=0, ALIGN is skipped.
  - LOCKED: pcnt increments every cycle and hcnt += s.
    - At pcnt==FULL: duty_o <= hcnt+s, duty_valid_o strobes, acc += hcnt+s, hcnt <= 0, pcnt wraps, scnt++.
    - At pcnt==FULL and scnt==15: value_o <= acc+hcnt+s, value_valid_o strobes, acc <= 0.
- Sync supervision:
  - tcnt resets to 0 on every accepted sync_i and otherwise increments, saturating.
  - The next sync is expected exactly at tcnt==16*(FULL+1)-1.
  - sync_i at any other tcnt in LOCKED: err_o <= 1, locked_o <= 0, the partial frame is discarded with no value strobe, and the FSM re-enters ALIGN using this pulse.
  - No sync_i at the expected tcnt: err_o <= 1, go to SEARCH.
- locked_o=1 only in LOCKED.
- Simultaneous err_clr_i and a new error: err_o stays 1 (set wins).
- Widths: all sums are unsigned and cannot overflow. Maximum value_o is 4096, which needs 13 bits.

## Timing
- Every output resets to 0: duty_o, duty_valid_o, value_o, value_valid_o, locked_o, err_o. The FSM resets to SEARCH.
- Latency: sample s is counted in the cycle it appears. duty_valid_o and value_valid_o are registered: they assert the cycle after the last sample of the period, and the data is valid in the same cycle.
- pwm_i to s delay is SYNC_STAGES cycles. The transmitter-to-frame phase is set only through SYNC_DLY.
- Frame alignment: sync_i high in cycle t makes the first counted sample arrive at t+1+SYNC_DLY.
- Reset mid-frame: all state clears immediately, asynchronously; no strobes until a new sync_i arrives and one full period completes.
- Strobes are never held longer than one cycle. There is no backpressure; consumers must capture on the strobe.

## Structure
- Package red_pitaya_pwm_pkg holds:
  - the FSM enum (SEARCH, ALIGN, LOCKED),
  - NSUB=16,
  - the FRAME_LEN=NSUB*(FULL+1) function,
  - the duty width (9) and value width (13) constants.
- One sub-module: red_pitaya_sync_ff, an N-stage synchronizer for pwm_i with a parameterized stage count.

## Test plan
1. Constant high, SYNC_STAGES=0, SYNC_DLY=0, valid sync every 4096 cycles -> duty_o=256 on every strobe, value_o=4096, locked_o=1, err_o=0.
2. Periods with high counts 0x12 plus dither bits 0x3456 (LSB first, periods 0..15) -> duty_o sequence 0x12/0x13 per bit, value_o=16*0x12+7=295.
3. Sync pulse early by 1 cycle in the third frame -> err_o=1, no value strobe for the broken frame, the next full frame reports the correct value.
4. Sync pulses stop -> err_o=1 and locked_o=0 at the expected tcnt; err_clr_i pulse clears err_o; restarting syncs relocks.
5. Assert rstn low mid-frame at pcnt=100 -> all outputs are 0 at once; after release, no strobes before the first sync plus FULL+1+SYNC_DLY cycles.
6. SYNC_STAGES=2, SYNC_DLY=2, all-zero waveform with a single high sample at pcnt=FULL -> that sample is counted in the correct period (duty_o=1 in subperiod 0 only).
